// File: rtl/pixel_readout_if.sv
// Pixel stream interface: one pixel per valid/ready transfer, tagged with
// its row/column coordinates and an end-of-frame flag.
interface pixel_readout_if #(
    parameter int W = 4,
    parameter int H = 4
);
    localparam int RW  = (H > 1) ? $clog2(H) : 1;
    localparam int CLW = (W > 1) ? $clog2(W) : 1;

    logic [7:0]     pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic [RW-1:0]  pix_row;
    logic [CLW-1:0] pix_col;
    logic           pix_last;

    modport master (
        output pix_data, pix_valid, pix_row, pix_col, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_row, pix_col, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_readout.sv
// Row-sequenced pixel array readout: enables one row, waits SETTLE extra
// cycles, latches the row from the shared data bus, then streams its pixels.
module pixel_readout #(
    parameter int W      = 4,
    parameter int H      = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [H-1:0]             readbus,
    input  logic [H-1:0][W-1:0][7:0] databus,
    output logic                     busy,
    output logic                     done,
    pixel_readout_if.master          pix
);
    localparam int RW  = (H > 1) ? $clog2(H) : 1;
    localparam int CLW = (W > 1) ? $clog2(W) : 1;
    localparam int CW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [H-1:0] ROW0 = H'(1);

    typedef enum logic [1:0] {IDLE, SELECT, STREAM, FINISH} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      row;
    logic [CLW-1:0]     col;
    logic [CW-1:0]      cnt;
    logic [W-1:0][7:0]  rowbuf;
    logic               xfer, row_end, frame_end, capture;

    assign xfer      = (state == STREAM) && pix.pix_ready;
    assign row_end   = (col == CLW'(W - 1));
    assign frame_end = row_end && (row == RW'(H - 1));
    assign capture   = (state == SELECT) && (cnt == CW'(SETTLE));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and outputs; all outputs decode from state so reset clears
    // them without waiting for a clock edge
    always_comb begin
        state_nxt     = state;
        readbus       = '0;
        busy          = 1'b1;
        done          = 1'b0;
        pix.pix_valid = 1'b0;
        pix.pix_data  = 8'h00;
        pix.pix_last  = 1'b0;
        pix.pix_row   = row;
        pix.pix_col   = col;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SELECT;
            end
            SELECT: begin
                readbus = ROW0 << row;
                if (capture) state_nxt = STREAM;
            end
            STREAM: begin
                pix.pix_valid = 1'b1;
                pix.pix_data  = rowbuf[col];
                pix.pix_last  = frame_end;
                if (xfer && row_end) state_nxt = frame_end ? FINISH : SELECT;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Row/column/settle counters and row buffer; the buffer only loads on
    // the capture edge so the data bus is ignored while streaming
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row    <= '0;
            col    <= '0;
            cnt    <= '0;
            rowbuf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row <= '0;
                        col <= '0;
                        cnt <= '0;
                    end
                end
                SELECT: begin
                    if (capture) begin
                        rowbuf <= databus[row];
                        col    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (!row_end) begin
                            col <= col + CLW'(1);
                        end else if (!frame_end) begin
                            row <= row + RW'(1);
                            cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: one instance with SETTLE=2 for the main
// scenarios and one with SETTLE=0 for the minimum-settle timing.
module tb_pixel_readout;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic start0 = 1'b0;
    logic [H-1:0][W-1:0][7:0] databus, pattern;
    logic [H-1:0] readbus, readbus0;
    logic busy, done, busy0, done0;

    pixel_readout_if #(.W(W), .H(H)) pix ();
    pixel_readout_if #(.W(W), .H(H)) pix0 ();

    pixel_readout #(.W(W), .H(H), .SETTLE(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .readbus(readbus),
        .databus(databus), .busy(busy), .done(done), .pix(pix)
    );

    pixel_readout #(.W(W), .H(H), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .readbus(readbus0),
        .databus(databus), .busy(busy0), .done(done0), .pix(pix0)
    );

    assign pix0.pix_ready = 1'b1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state (written only by the monitor, read by the sequence)
    logic [12:0]  xq[$];
    int           xc[$];
    logic [H-1:0] rbq[$];
    logic [H-1:0] rb_prev = '0;
    int           rb_cnt[H];
    int           done_cnt = 0, done_cyc = 0, viol = 0;
    logic         stall_prev = 1'b0;
    logic [12:0]  stall_word = '0;
    int           rb0_cnt[H];
    int           done0_cnt = 0, done0_cyc = 0;
    int           v0q[$];
    logic         v0_prev = 1'b0;

    // Sample everything mid-cycle; inputs only change just after posedge
    always @(negedge clk) begin
        logic [12:0] w;
        w = {pix.pix_last, pix.pix_row, pix.pix_col, pix.pix_data};
        if (pix.pix_valid && pix.pix_ready) begin
            xq.push_back(w);
            xc.push_back(cyc);
        end
        if (stall_prev && (!pix.pix_valid || w != stall_word)) viol++;
        stall_prev = pix.pix_valid && !pix.pix_ready;
        stall_word = w;
        if ($countones(readbus) > 1 || (readbus != '0 && pix.pix_valid)) viol++;
        if (readbus != '0 && readbus != rb_prev) rbq.push_back(readbus);
        rb_prev = readbus;
        for (int i = 0; i < H; i++) begin
            if (readbus[i]) rb_cnt[i]++;
            if (readbus0[i]) rb0_cnt[i]++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (done0) begin done0_cnt++; done0_cyc = cyc; end
        if (pix0.pix_valid && !v0_prev) v0q.push_back(cyc);
        v0_prev = pix0.pix_valid;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected frame: pixel (r,c) = 16r+c in raster order, last flag on (3,3)
    task automatic check_frame(input string tag, input int xb);
        chk({tag, "_count"}, 32'(xq.size() - xb), 32'd16);
        for (int k = 0; k < 16; k++) begin
            int rr, cc;
            logic [12:0] e;
            rr = k / 4;
            cc = k % 4;
            e = {(k == 15), 2'(rr), 2'(cc), 8'(16 * rr + cc)};
            if (xb + k < xq.size()) chk($sformatf("%s_px%0d", tag, k), 32'(xq[xb + k]), 32'(e));
        end
    endtask

    int xb, db, vb, rbb, t0, d0b, v0b;
    int rbc[H];
    int rb0c[H];

    initial begin
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) pattern[i][j] = 8'(16 * i + j);

        // Reset with noisy inputs
        pix.pix_ready = 1'b1;
        databus = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_readbus", 32'(readbus), 32'd0);
        chk("rst_valid", 32'(pix.pix_valid), 32'd0);
        chk("rst_data", 32'(pix.pix_data), 32'd0);
        chk("rst_row", 32'(pix.pix_row), 32'd0);
        chk("rst_col", 32'(pix.pix_col), 32'd0);
        chk("rst_last", 32'(pix.pix_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        #2;
        start = 1'b0;
        start0 = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_readbus", 32'(readbus), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        databus = pattern;

        // Full frame, ready high, START re-pulsed in SELECT and in STREAM
        @(posedge clk); #1;
        xb = xq.size(); db = done_cnt; vb = viol; rbb = rbq.size(); rbc = rb_cnt;
        start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 100 && done_cnt == db; k++) begin
            @(posedge clk); #1;
            start = (k == 2 || k == 5);
        end
        repeat (5) @(negedge clk);
        chk("t2_done_once", 32'(done_cnt - db), 32'd1);
        chk("t2_done_cyc", 32'(done_cyc - t0), 32'd28);
        chk("t2_no_requeue", 32'(busy), 32'd0);
        check_frame("t2", xb);
        if (xq.size() > xb) chk("t2_first_cyc", 32'(xc[xb] - t0), 32'd3);
        if (xq.size() >= xb + 16) chk("t2_last_cyc", 32'(xc[xb + 15] - t0), 32'd27);
        chk("t2_rb_count", 32'(rbq.size() - rbb), 32'd4);
        for (int i = 0; i < H; i++) begin
            if (rbb + i < rbq.size()) chk($sformatf("t2_rb_seq%0d", i), 32'(rbq[rbb + i]), 32'd1 << i);
            chk($sformatf("t2_rb_len%0d", i), 32'(rb_cnt[i] - rbc[i]), 32'd3);
        end
        chk("t2_protocol", 32'(viol - vb), 32'd0);

        // Backpressure, data bus scribbled while streaming
        @(posedge clk); #1;
        xb = xq.size(); db = done_cnt; vb = viol;
        start = 1'b1;
        for (int k = 0; k < 400 && done_cnt == db; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            pix.pix_ready = ($urandom_range(0, 2) != 0);
            databus = pix.pix_valid ? '1 : pattern;
        end
        databus = pattern;
        pix.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_done_once", 32'(done_cnt - db), 32'd1);
        check_frame("t3", xb);
        chk("t3_protocol", 32'(viol - vb), 32'd0);

        // START held through DONE starts the next frame right after DONE
        @(posedge clk); #1;
        db = done_cnt;
        start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 100 && done_cnt == db; k++) begin
            @(posedge clk); #1;
        end
        chk("t4_done_cyc", 32'(done_cyc - t0), 32'd28);
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_readbus", 32'(readbus), 32'd0);
        @(negedge clk);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        chk("t4_restart_readbus", 32'(readbus), 32'd1);
        start = 1'b0;

        // Reset while streaming row 2 of that second frame
        for (int k = 0; k < 100 && !(pix.pix_valid && pix.pix_row == 2'd2); k++) @(negedge clk);
        chk("t5_in_row2", 32'(pix.pix_valid && pix.pix_row == 2'd2), 32'd1);
        db = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(pix.pix_valid), 32'd0);
        chk("t5_async_readbus", 32'(readbus), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_data", 32'(pix.pix_data), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - db), 32'd0);

        // Fresh frame after the abort starts again from row 0, col 0
        @(posedge clk); #1;
        xb = xq.size(); db = done_cnt;
        start = 1'b1;
        for (int k = 0; k < 100 && done_cnt == db; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_frame("t6", xb);

        // SETTLE=0 instance
        @(posedge clk); #1;
        rb0c = rb0_cnt; d0b = done0_cnt; v0b = v0q.size();
        start0 = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 100 && done0_cnt == d0b; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("t7_done_once", 32'(done0_cnt - d0b), 32'd1);
        chk("t7_done_cyc", 32'(done0_cyc - t0), 32'd20);
        if (v0q.size() > v0b) chk("t7_first_valid", 32'(v0q[v0b] - t0), 32'd1);
        else chk("t7_first_valid", 32'd0, 32'd1);
        for (int i = 0; i < H; i++)
            chk($sformatf("t7_rb_len%0d", i), 32'(rb0_cnt[i] - rb0c[i]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
